seq_decoder: RTL and testbench

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder.sv | 119 +++++++++++
 tb/tb_seq_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// Microcode step decoder: follows the FSA sequencer state, counts instruction steps and drives registered control lines.
// Optional jump checking on seq_err is built only when SEQ_DECODE_ERRCHK_EN is defined.
module seq_decoder (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] fsm_state,
    input  logic [7:0] instr,
    input  logic       run,
    output logic [9:0] ctrl,
    output logic       abort,
    output logic       halted,
    output logic       seq_err
);

    typedef enum logic [1:0] {
        CLS_MOV8 = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_SETA = 2'b10,
        CLS_GOTO = 2'b11
    } instr_class_t;

    logic [2:0]   fsm_prev;
    logic [4:0]   step, step_next, last_step;
    instr_class_t cls, cls_next;
    logic         halted_next, abort_next, advance;
    logic [9:0]   ctrl_dec;

    // A sequencer move only counts while running and not halted; the jump size never matters.
    assign advance = run && !halted && (fsm_state != fsm_prev);

    always_comb begin
        last_step = 5'd23;
        unique case (cls)
            CLS_MOV8, CLS_ALU: last_step = 5'd11;
            CLS_SETA:          last_step = 5'd9;
            CLS_GOTO:          last_step = 5'd23;
        endcase
    end

    // State register: every cycle the sequencer state is remembered, step/class/halt move on advances.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_prev <= 3'd0;
            step     <= 5'd0;
            cls      <= CLS_MOV8;
            halted   <= 1'b0;
            abort    <= 1'b0;
            ctrl     <= 10'd0;
        end else begin
            fsm_prev <= fsm_state;
            step     <= step_next;
            cls      <= cls_next;
            halted   <= halted_next;
            abort    <= abort_next;
            ctrl     <= ctrl_dec;
        end
    end

    // Next state: the fetch->execute boundary latches the class (last_step is never 7, so order is safe).
    always_comb begin
        step_next   = step;
        cls_next    = cls;
        halted_next = halted;
        abort_next  = 1'b0;
        if (advance) begin
            if (step == 5'd7) begin
                step_next = 5'd8;
                cls_next  = instr_class_t'(instr[7:6]);
                if (instr == 8'hAE) begin
                    halted_next = 1'b1;
                end
            end else if (step == last_step) begin
                step_next  = 5'd0;
                abort_next = 1'b1;
            end else begin
                step_next = step + 5'd1;
            end
        end
    end

    // Output decode of the current step; registered above so ctrl trails the step by one cycle.
    always_comb begin
        ctrl_dec = 10'd0;
        if (!halted) begin
            ctrl_dec[0] = (step <= 5'd3);
            ctrl_dec[1] = (step >= 5'd1) && (step <= 5'd3);
            ctrl_dec[2] = (step == 5'd2);
            ctrl_dec[3] = (step == 5'd4);
            ctrl_dec[4] = (step == 5'd5) || (step == 5'd6);
            ctrl_dec[5] = (step == 5'd6) || ((cls == CLS_GOTO) && (step == 5'd22));
            ctrl_dec[6] = (((cls == CLS_MOV8) || (cls == CLS_ALU)) && (step >= 5'd8) && (step <= 5'd10))
                        || ((cls == CLS_SETA) && ((step == 5'd8) || (step == 5'd9)));
            ctrl_dec[7] = (((cls == CLS_MOV8) || (cls == CLS_ALU)) && (step == 5'd9))
                        || ((cls == CLS_SETA) && (step == 5'd8));
            ctrl_dec[8] = (cls == CLS_ALU) && (step >= 5'd8) && (step <= 5'd10);
            ctrl_dec[9] = (cls == CLS_GOTO) && ((step == 5'd10) || (step == 5'd16));
        end
    end

`ifdef SEQ_DECODE_ERRCHK_EN
    logic       seq_err_q;
    logic [2:0] expected_state;

    assign expected_state = fsm_prev + 3'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_err_q <= 1'b0;
        end else if (advance && (fsm_state != expected_state)) begin
            seq_err_q <= 1'b1;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder: vector table, directed corner sequences and a randomized run
// against a step-level reference model.
module tb_seq_decoder;

    logic       clock, reset, run;
    logic [2:0] fsm_state;
    logic [7:0] instr;
    logic [9:0] ctrl;
    logic       abort, halted, seq_err;

    seq_decoder dut (
        .clock     (clock),
        .reset     (reset),
        .fsm_state (fsm_state),
        .instr     (instr),
        .run       (run),
        .ctrl      (ctrl),
        .abort     (abort),
        .halted    (halted),
        .seq_err   (seq_err)
    );

`ifdef SEQ_DECODE_ERRCHK_EN
    localparam bit ERR_EXP = 1'b1;
`else
    localparam bit ERR_EXP = 1'b0;
`endif

    typedef struct {
        logic [2:0] fs;
        logic [7:0] ins;
        logic       r;
        logic [9:0] exp_ctrl;
        logic       exp_abort;
        logic       exp_halted;
    } vector_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         lens [4] = '{12, 12, 10, 24};
    int         m_prev, m_step, m_cls;
    bit         m_halted, m_err, m_abort;
    logic [9:0] m_ctrl;
    logic [2:0] cur_fs;
    vector_t    vecs [13];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Control lines as a direct reading of the step/class bit map.
    function automatic logic [9:0] ctrl_of(input int step, input int cls);
        logic [9:0] b;
        bit         mov_alu;
        b       = '0;
        mov_alu = (cls == 0) || (cls == 1);
        b[0] = (step <= 3);
        b[1] = (step >= 1) && (step <= 3);
        b[2] = (step == 2);
        b[3] = (step == 4);
        b[4] = (step == 5) || (step == 6);
        b[5] = (step == 6) || ((cls == 3) && (step == 22));
        b[6] = (mov_alu && step >= 8 && step <= 10) || ((cls == 2) && (step == 8 || step == 9));
        b[7] = (mov_alu && step == 9) || ((cls == 2) && (step == 8));
        b[8] = (cls == 1) && (step >= 8) && (step <= 10);
        b[9] = (cls == 3) && (step == 10 || step == 16);
        return b;
    endfunction

    function automatic logic [12:0] dut_out();
        return {ctrl, abort, halted, seq_err};
    endfunction

    function automatic logic [12:0] model_out();
        return {m_ctrl, m_abort, m_halted, m_err};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_model(input string name);
        check_output(name, {19'd0, dut_out()}, {19'd0, model_out()});
    endtask

    task automatic model_edge(input logic [2:0] fs, input logic [7:0] ins, input logic r);
        bit adv;
        adv     = r && !m_halted && (int'(fs) != m_prev);
        m_ctrl  = m_halted ? 10'd0 : ctrl_of(m_step, m_cls);
        m_abort = 1'b0;
        if (ERR_EXP && adv && (int'(fs) != (m_prev + 1) % 8)) m_err = 1'b1;
        if (adv) begin
            if (m_step == 7) begin
                m_cls  = int'(ins[7:6]);
                m_step = 8;
                if (ins == 8'hAE) m_halted = 1'b1;
            end else if (m_step == lens[m_cls] - 1) begin
                m_step  = 0;
                m_abort = 1'b1;
            end else begin
                m_step++;
            end
        end
        m_prev = int'(fs);
    endtask

    task automatic apply_stimulus(input logic [2:0] fs, input logic [7:0] ins, input logic r);
        fsm_state = fs;
        instr     = ins;
        run       = r;
        model_edge(fs, ins, r);
        @(posedge clock);
        #1;
    endtask

    // Reset is raised mid-cycle so the zero check proves it acts without a clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_output("reset_state", {19'd0, dut_out()}, 32'd0);
        m_prev = 0; m_step = 0; m_cls = 0;
        m_halted = 1'b0; m_err = 1'b0; m_abort = 1'b0; m_ctrl = 10'd0;
        cur_fs = 3'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_steps(input int n, input logic [7:0] ins, input string name);
        for (int i = 0; i < n; i++) begin
            cur_fs = cur_fs + 3'd1;
            apply_stimulus(cur_fs, ins, 1'b1);
            check_model(name);
        end
    endtask

    initial begin
        logic [31:0] seen_ldm, seen_ldpc, seen_abort, halt_activity;
        logic [7:0]  rins;
        logic        rrun;
        int          k;

        reset = 1'b1; run = 1'b0; fsm_state = 3'd0; instr = 8'd0; cur_fs = 3'd0;
        #2;
        do_reset();

        // MOV8 instruction: ctrl trails step by one cycle, abort on the 12th advance.
        vecs[0]  = '{3'd1, 8'h12, 1'b1, 10'h001, 1'b0, 1'b0};
        vecs[1]  = '{3'd2, 8'h12, 1'b1, 10'h003, 1'b0, 1'b0};
        vecs[2]  = '{3'd3, 8'h12, 1'b1, 10'h007, 1'b0, 1'b0};
        vecs[3]  = '{3'd4, 8'h12, 1'b1, 10'h003, 1'b0, 1'b0};
        vecs[4]  = '{3'd5, 8'h12, 1'b1, 10'h008, 1'b0, 1'b0};
        vecs[5]  = '{3'd6, 8'h12, 1'b1, 10'h010, 1'b0, 1'b0};
        vecs[6]  = '{3'd7, 8'h12, 1'b1, 10'h030, 1'b0, 1'b0};
        vecs[7]  = '{3'd0, 8'h12, 1'b1, 10'h000, 1'b0, 1'b0};
        vecs[8]  = '{3'd1, 8'h12, 1'b1, 10'h040, 1'b0, 1'b0};
        vecs[9]  = '{3'd2, 8'h12, 1'b1, 10'h0C0, 1'b0, 1'b0};
        vecs[10] = '{3'd3, 8'h12, 1'b1, 10'h040, 1'b0, 1'b0};
        vecs[11] = '{3'd4, 8'h12, 1'b1, 10'h000, 1'b1, 1'b0};
        vecs[12] = '{3'd4, 8'h12, 1'b1, 10'h001, 1'b0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].fs, vecs[i].ins, vecs[i].r);
            check_output($sformatf("mov8_vec%0d", i), {19'd0, dut_out()},
                         {19'd0, vecs[i].exp_ctrl, vecs[i].exp_abort, vecs[i].exp_halted, 1'b0});
            check_model($sformatf("mov8_model%0d", i));
        end

        // GOTO: 24-step instruction, record which advance each strobe follows.
        do_reset();
        seen_ldm = '0; seen_ldpc = '0; seen_abort = '0;
        for (int j = 1; j <= 25; j++) begin
            if (j <= 24) cur_fs = cur_fs + 3'd1;
            apply_stimulus(cur_fs, 8'hC0, 1'b1);
            check_model("goto_model");
            seen_ldm[j]   = ctrl[9];
            seen_ldpc[j]  = ctrl[5];
            seen_abort[j] = abort;
        end
        check_output("goto_ld_m", seen_ldm, 32'h0002_0800);
        check_output("goto_ld_pc", seen_ldpc, 32'h0080_0080);
        check_output("goto_abort", seen_abort, 32'h0100_0000);

        // HALT opcode freezes everything until reset.
        do_reset();
        run_steps(8, 8'hAE, "halt_model");
        check_output("halt_set", {20'd0, ctrl, abort, halted}, {20'd0, 10'd0, 1'b0, 1'b1});
        halt_activity = '0;
        for (int i = 0; i < 6; i++) begin
            cur_fs = cur_fs + 3'd1;
            apply_stimulus(cur_fs, 8'h12, 1'b1);
            check_model("halt_frozen_model");
            halt_activity = halt_activity | {21'd0, ctrl, abort} | {31'd0, !halted};
        end
        check_output("halt_frozen", halt_activity, 32'd0);
        do_reset();
        check_output("halt_cleared", {31'd0, halted}, 32'd0);

        // run low at step 3 while the sequencer moves twice (first move coincides with run falling).
        do_reset();
        run_steps(3, 8'h40, "freeze_model");
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("freeze_pre", {22'd0, ctrl}, 32'h003);
        for (int i = 0; i < 5; i++) begin
            if (i < 2) cur_fs = cur_fs + 3'd1;
            apply_stimulus(cur_fs, 8'h40, 1'b0);
            check_output("freeze_hold", {21'd0, ctrl, abort}, {21'd0, 10'h003, 1'b0});
            check_model("freeze_hold_model");
        end
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("freeze_rerun", {22'd0, ctrl}, 32'h003);
        cur_fs = cur_fs + 3'd1;
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("freeze_resume_step4", {22'd0, ctrl}, 32'h008);

        // Jump 2->5: still one step, seq_err only with the checker built in.
        do_reset();
        run_steps(2, 8'h40, "jump_model");
        cur_fs = 3'd5;
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("jump_err", {31'd0, seq_err}, {31'd0, ERR_EXP});
        cur_fs = cur_fs + 3'd1;
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("jump_step4", {22'd0, ctrl}, 32'h008);
        check_output("jump_err_sticky", {31'd0, seq_err}, {31'd0, ERR_EXP});

        // Reset in the middle of an ALU instruction, then restart from fsm_prev = 0.
        do_reset();
        run_steps(9, 8'h40, "midreset_model");
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("midreset_pre", {22'd0, ctrl}, 32'h1C0);
        do_reset();
        cur_fs = 3'd1;
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("midreset_ctrl0", {22'd0, ctrl}, 32'h001);
        apply_stimulus(cur_fs, 8'h40, 1'b1);
        check_output("midreset_step1", {22'd0, ctrl}, 32'h003);

        // Randomized run against the reference model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                k = int'($urandom_range(0, 9));
                if (k < 6) cur_fs = cur_fs + 3'd1;
                else if (k >= 8) cur_fs = 3'($urandom_range(0, 7));
                rrun = ($urandom_range(0, 9) != 0);
                rins = ($urandom_range(0, 7) == 0) ? 8'hAE : 8'($urandom);
                apply_stimulus(cur_fs, rins, rrun);
                check_model("random");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
